matmul_engine: RTL and testbench

Parametrised successor to the 4x4 byte-serial matrix loader/multiplier. Takes a DIM x DIM feature matrix A and weight matrix W over two serial write ports, computes C = A x W with a single multiply-accumulate unit on startSignal, and streams C out row-major through a valid/ready port. Width, dimension and accumulator size are generics. Start, busy and done handshakes and error flags make it usable under a controller FSM, not only a bench.

---
 rtl/matmul_engine.sv | 192 +++++++++++++++++++
 tb/tb_matmul_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// Serial-load DIM x DIM matrix multiplier: loads A and W element by element, computes
// C = A x W on one multiply-accumulate unit, then streams C row-major over valid/ready.
module matmul_engine #(
  parameter int DATA_W = 8,
  parameter int DIM    = 4,
  parameter int ACC_W  = 2*DATA_W+$clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] port_A,
  input  logic              write_enable_A,
  input  logic [DATA_W-1:0] port_W,
  input  logic              write_enable_W,
  input  logic              startSignal,
  output logic              busy,
  output logic [ACC_W-1:0]  port_O,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              start_err,
  output logic              load_ovf
);

  localparam int LOG_DIM = $clog2(DIM);
  localparam int IDX_W   = 2*LOG_DIM;
  localparam int CNT_W   = IDX_W+1;
  localparam int NELEM   = DIM*DIM;
  localparam logic [CNT_W-1:0]   FULL     = CNT_W'(NELEM);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NELEM-1);
  localparam logic [LOG_DIM-1:0] LAST_K   = LOG_DIM'(DIM-1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cntA_q, cntA_d, cntW_q, cntW_d;
  logic [LOG_DIM-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [IDX_W-1:0]   rd_q, rd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   portO_q, portO_d;
  logic               outValid_q, outValid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               startErr_q, startErr_d;
  logic               loadOvf_q, loadOvf_d;

  logic [DATA_W-1:0]  aMem [NELEM];
  logic [DATA_W-1:0]  wMem [NELEM];
  logic [ACC_W-1:0]   cMem [NELEM];
  logic               aWrEn, wWrEn, cWrEn;
  logic [ACC_W-1:0]   macSum;

  // DIM is a power of two, so {row,col} concatenation is the row-major address.
  always_comb begin
    macSum = ((k_q == '0) ? '0 : acc_q)
           + ACC_W'(aMem[{i_q, k_q}]) * ACC_W'(wMem[{k_q, j_q}]);
  end

  always_comb begin
    state_d    = state_q;
    cntA_d     = cntA_q;
    cntW_d     = cntW_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    rd_d       = rd_q;
    acc_d      = acc_q;
    portO_d    = portO_q;
    outValid_d = outValid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    startErr_d = 1'b0;
    loadOvf_d  = 1'b0;
    aWrEn      = 1'b0;
    wWrEn      = 1'b0;
    cWrEn      = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_enable_A) begin
          if (cntA_q != FULL) begin
            aWrEn  = 1'b1;
            cntA_d = cntA_q + 1'b1;
          end else begin
            loadOvf_d = 1'b1;
          end
        end
        if (write_enable_W) begin
          if (cntW_q != FULL) begin
            wWrEn  = 1'b1;
            cntW_d = cntW_q + 1'b1;
          end else begin
            loadOvf_d = 1'b1;
          end
        end
        if (startSignal) begin
          if (cntA_q == FULL && cntW_q == FULL) begin
            state_d = COMPUTE;
            busy_d  = 1'b1;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end else begin
            startErr_d = 1'b1;
          end
        end
      end
      COMPUTE: begin
        acc_d = macSum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST_K) begin
          cWrEn = 1'b1;
          j_d   = j_q + 1'b1;
          if (j_q == LAST_K) begin
            i_d = i_q + 1'b1;
            if (i_q == LAST_K) begin
              state_d = DRAIN;
              rd_d    = '0;
            end
          end
        end
      end
      DRAIN: begin
        // The first element is fetched one cycle after entering DRAIN.
        if (!outValid_q) begin
          portO_d    = cMem[rd_q];
          outValid_d = 1'b1;
        end else if (out_ready) begin
          if (rd_q == LAST_IDX) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            outValid_d = 1'b0;
            cntA_d     = '0;
            cntW_d     = '0;
          end else begin
            rd_d    = rd_q + 1'b1;
            portO_d = cMem[rd_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cntA_q     <= '0;
      cntW_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      rd_q       <= '0;
      acc_q      <= '0;
      portO_q    <= '0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      startErr_q <= 1'b0;
      loadOvf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cntA_q     <= cntA_d;
      cntW_q     <= cntW_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      rd_q       <= rd_d;
      acc_q      <= acc_d;
      portO_q    <= portO_d;
      outValid_q <= outValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      startErr_q <= startErr_d;
      loadOvf_q  <= loadOvf_d;
    end
  end

  // Storage needs no reset; the counters alone decide what is valid.
  always_ff @(posedge clk) begin
    if (aWrEn && !rst) aMem[cntA_q[IDX_W-1:0]] <= port_A;
    if (wWrEn && !rst) wMem[cntW_q[IDX_W-1:0]] <= port_W;
    if (cWrEn && !rst) cMem[{i_q, j_q}] <= macSum;
  end

  assign busy      = busy_q;
  assign port_O    = portO_q;
  assign out_valid = outValid_q;
  assign done      = done_q;
  assign start_err = startErr_q;
  assign load_ovf  = loadOvf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: 4x4 default instance plus a DIM=2, DATA_W=16 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_matmul_engine;

  typedef logic [7:0]  mat_t [16];
  typedef logic [63:0] res_t [16];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  portA = '0, portW = '0;
  logic        weA = 1'b0, weW = 1'b0, startSig = 1'b0, outReady = 1'b1;
  logic        busy, outValid, done, startErr, loadOvf;
  logic [17:0] portO;

  logic [15:0] sPortA = '0, sPortW = '0;
  logic        sWeA = 1'b0, sWeW = 1'b0, sStart = 1'b0, sOutReady = 1'b1;
  logic        sBusy, sOutValid, sDone, sStartErr, sLoadOvf;
  logic [32:0] sPortO;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matmul_engine dut (
    .clk(clk), .rst(rst),
    .port_A(portA), .write_enable_A(weA),
    .port_W(portW), .write_enable_W(weW),
    .startSignal(startSig), .busy(busy),
    .port_O(portO), .out_valid(outValid), .out_ready(outReady),
    .done(done), .start_err(startErr), .load_ovf(loadOvf)
  );

  matmul_engine #(.DATA_W(16), .DIM(2)) dutSmall (
    .clk(clk), .rst(rst),
    .port_A(sPortA), .write_enable_A(sWeA),
    .port_W(sPortW), .write_enable_W(sWeW),
    .startSignal(sStart), .busy(sBusy),
    .port_O(sPortO), .out_valid(sOutValid), .out_ready(sOutReady),
    .done(sDone), .start_err(sStartErr), .load_ovf(sLoadOvf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input mat_t a, input mat_t w);
    for (int n = 0; n < 16; n++) begin
      portA = a[n]; weA = 1'b1;
      portW = w[n]; weW = 1'b1;
      @(negedge clk);
    end
    weA = 1'b0;
    weW = 1'b0;
  endtask

  task automatic pulseStart();
    startSig = 1'b1;
    @(negedge clk);
    startSig = 1'b0;
  endtask

  task automatic waitFirstValid(input string tag, input int expLatency);
    int cyc = 0;
    while (!outValid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " first valid latency"}, cyc, expLatency);
  endtask

  // Each valid cycle compares port_O against the element still owed, so a stalled
  // output that changes, repeats or skips is caught.
  task automatic drainAndCheck(input string tag, input res_t expC, input bit randomReady, output int cycles);
    int got = 0;
    cycles = 0;
    while (got < 16 && cycles < 400) begin
      outReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (outValid) begin
        checkOutput($sformatf("%s C%0d", tag, got), portO, expC[got]);
        if (outReady) got++;
      end
      @(negedge clk);
      cycles++;
    end
    outReady = 1'b1;
    checkOutput({tag, " element count"}, got, 16);
    checkOutput({tag, " done pulse"}, done, 1);
    checkOutput({tag, " busy falls"}, busy, 0);
    checkOutput({tag, " valid falls"}, outValid, 0);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    mat_t aDir, wDir, aMax;
    res_t expDir, expMax;
    logic [63:0] rowVals [4];
    logic [63:0] smallExp [4];
    logic [15:0] smallA [4];
    logic [15:0] smallW [4];
    int cycles;
    int cyc;

    wDir = '{8'd4, 8'd0, 8'd2, 8'd1,  8'd4, 8'd3, 8'd2, 8'd0,
             8'd4, 8'd3, 8'd0, 8'd1,  8'd4, 8'd3, 8'd2, 8'd1};
    rowVals = '{64'd40, 64'd27, 64'd14, 64'd8};
    for (int n = 0; n < 16; n++) begin
      aDir[n]   = 8'((n % 4) + 1);
      aMax[n]   = 8'd255;
      expDir[n] = rowVals[n % 4];
      expMax[n] = 64'd260100;
    end

    // Reset state
    @(negedge clk);
    resetDut();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset port_O", portO, 0);
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset start_err", startErr, 0);
    checkOutput("reset load_ovf", loadOvf, 0);

    // Directed run with out_ready held high
    applyStimulus(aDir, wDir);
    pulseStart();
    checkOutput("directed busy rises", busy, 1);
    waitFirstValid("directed", 65);
    drainAndCheck("directed", expDir, 1'b0, cycles);
    checkOutput("directed valid-to-done cycles", cycles, 16);

    // Start with only 15 A elements loaded is rejected
    for (int n = 0; n < 16; n++) begin
      portW = wDir[n]; weW = 1'b1;
      portA = aDir[n]; weA = (n < 15);
      @(negedge clk);
    end
    weA = 1'b0; weW = 1'b0;
    pulseStart();
    checkOutput("partial start_err", startErr, 1);
    checkOutput("partial busy", busy, 0);
    @(negedge clk);
    checkOutput("start_err one cycle", startErr, 0);

    // 16th A write fills, 17th overflows and must not disturb A[15]
    portA = aDir[15]; weA = 1'b1;
    @(negedge clk);
    checkOutput("16th write no ovf", loadOvf, 0);
    portA = 8'd99;
    @(negedge clk);
    weA = 1'b0;
    checkOutput("17th write load_ovf", loadOvf, 1);
    @(negedge clk);
    checkOutput("load_ovf one cycle", loadOvf, 0);

    // Writes and a start during COMPUTE are ignored; drain with random backpressure
    pulseStart();
    checkOutput("error run busy", busy, 1);
    for (int n = 0; n < 10; n++) begin
      portA = 8'd200; weA = 1'b1;
      portW = 8'd201; weW = 1'b1;
      startSig = (n == 4);
      @(negedge clk);
      if (n == 5) checkOutput("start in compute no err", startErr, 0);
      if (n == 6) checkOutput("write in compute no ovf", loadOvf, 0);
    end
    weA = 1'b0; weW = 1'b0; startSig = 1'b0;
    waitFirstValid("backpressure", 55);
    drainAndCheck("backpressure", expDir, 1'b1, cycles);

    // Reset in the middle of COMPUTE discards the operation
    applyStimulus(aDir, wDir);
    pulseStart();
    repeat (29) @(negedge clk);
    checkOutput("mid-compute busy", busy, 1);
    resetDut();
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset port_O", portO, 0);
    checkOutput("mid reset out_valid", outValid, 0);
    checkOutput("mid reset done", done, 0);
    pulseStart();
    checkOutput("after reset start_err", startErr, 1);
    checkOutput("after reset busy", busy, 0);

    // Reload with maximum values: no wrap in the default accumulator
    applyStimulus(aMax, aMax);
    pulseStart();
    waitFirstValid("max", 65);
    drainAndCheck("max", expMax, 1'b0, cycles);

    // DIM=2, DATA_W=16 instance
    smallA = '{16'd1, 16'd2, 16'd3, 16'd4};
    smallW = '{16'd5, 16'd6, 16'd7, 16'd8};
    smallExp = '{64'd19, 64'd22, 64'd43, 64'd50};
    for (int n = 0; n < 4; n++) begin
      sPortA = smallA[n]; sWeA = 1'b1;
      sPortW = smallW[n]; sWeW = 1'b1;
      @(negedge clk);
    end
    sWeA = 1'b0; sWeW = 1'b0;
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    checkOutput("small busy rises", sBusy, 1);
    cyc = 0;
    while (!sOutValid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("small first valid latency", cyc, 9);
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("small C%0d valid", n), sOutValid, 1);
      checkOutput($sformatf("small C%0d", n), sPortO, smallExp[n]);
      @(negedge clk);
    end
    checkOutput("small done", sDone, 1);
    checkOutput("small busy falls", sBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
